instr_mem_loader: RTL and testbench

Parametrised instruction memory for the IF stage, with a byte-stream program loader fed by the debug unit (UART side).
- Assembles incoming bytes into B-bit words, little-endian, and writes them sequentially.
- Tracks program length and exposes a registered fetch port to the PC.
- Flags misaligned and out-of-program fetches.
- Successor to the single-word write-pointer memory: adds byte assembly, a load FSM, a full flag, bounds checking and a synchronous read.

---
 rtl/instr_mem_pkg.sv | 13 +
 rtl/instr_mem_loader_byte_assembler.sv | 44 ++++
 rtl/instr_mem_loader.sv | 136 +++++++++++++
 tb/tb_instr_mem_loader.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: shared types and constants for the instruction memory loader
// Holds the load FSM state encoding, default word geometry and the NOP word.
package instr_mem_pkg;
  typedef enum logic [1:0] {IDLE, ASSEMBLE, WRITE, DONE} ld_state_t;
  localparam int DEF_B = 32;
  localparam int BYTES_PER_WORD = DEF_B / 8;
  localparam int LANE_W = $clog2(BYTES_PER_WORD);
  localparam logic [31:0] DEF_NOP = 32'h0000_0000;
  // Lane counter width for a B-bit word; at least one bit so B = 8 still builds.
  function automatic int lane_bits(input int b);
    return (b / 8 > 1) ? $clog2(b / 8) : 1;
  endfunction
endpackage

// File: rtl/instr_mem_loader_byte_assembler.sv
// byte_assembler: packs a byte stream into little-endian B-bit words
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_clear          drop any partial word (flush)
//   i_byte_en        accept i_byte into the next lane
//   i_byte           incoming byte
//   i_pad            close the partial word early (remaining lanes read as zero)
//   o_word           assembled word
//   o_word_ready     strobe: the word is complete after this edge
//   o_pending        at least one lane of the current word is filled
module byte_assembler
  import instr_mem_pkg::*;
#(
  parameter int B = DEF_B
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic         i_byte_en,
  input  logic [7:0]   i_byte,
  input  logic         i_pad,
  output logic [B-1:0] o_word,
  output logic         o_word_ready,
  output logic         o_pending
);
  localparam int BPW = B / 8;
  localparam int LW = lane_bits(B);
  logic [LW-1:0] r_lane;
  logic [B-1:0]  r_word;
  logic          w_last;
  assign w_last = r_lane == LW'(BPW - 1);
  assign o_pending = r_lane != '0;
  assign o_word = r_word;
  assign o_word_ready = (i_byte_en & w_last) | (i_pad & o_pending);
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear || i_pad) r_lane <= '0;
    else if (i_byte_en) r_lane <= w_last ? '0 : r_lane + 1'b1;
  end
  // Lane 0 clears the upper lanes, so an early pad already sees zeros there.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_word <= '0;
    else if (i_byte_en) r_word <= (r_lane == '0 ? '0 : r_word) | (B'(i_byte) << {r_lane, 3'b000});
  end
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: IF-stage instruction memory with a byte-stream program loader
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_load_valid/i_load_byte       program byte stream from the debug unit
//   o_load_ready                   loader accepts a byte this cycle
//   i_load_done                    end-of-program strobe
//   i_flush                        discard the program (contents kept)
//   i_fetch_en/i_addr              fetch request at byte address
//   o_instr/o_instr_valid          registered fetch result (one-cycle latency)
//   o_misaligned/o_out_of_range    flags for the last fetch
//   o_mem_full/o_prog_len/o_loaded program status
// Build option INSTR_MEM_DEBUG_PORT_EN adds i_dbg_addr/o_dbg_data, an unchecked
// registered read port used to dump memory.
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int B = 32,
  parameter int W = 10,
  parameter int PC = 32,
  parameter logic [B-1:0] NOP = B'(DEF_NOP)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load_valid,
  input  logic [7:0]    i_load_byte,
  output logic          o_load_ready,
  input  logic          i_load_done,
  input  logic          i_flush,
  input  logic          i_fetch_en,
  input  logic [PC-1:0] i_addr,
  output logic [B-1:0]  o_instr,
  output logic          o_instr_valid,
  output logic          o_misaligned,
  output logic          o_out_of_range,
  output logic          o_mem_full,
  output logic [W:0]    o_prog_len,
  output logic          o_loaded
`ifdef INSTR_MEM_DEBUG_PORT_EN
  ,
  input  logic [W-1:0]  i_dbg_addr,
  output logic [B-1:0]  o_dbg_data
`endif
);
  ld_state_t    r_state, w_next;
  logic [W:0]   r_prog_len;
  logic         r_done_lat;
  logic [B-1:0] r_mem [2**W];
  logic [B-1:0] r_instr;
  logic         r_instr_valid, r_mis, r_oor;
  logic         w_loading, w_hs, w_byte_en, w_pad, w_write, w_wrap, w_loaded;
  logic         w_word_ready, w_pending;
  logic [B-1:0] w_word;
  logic [W-1:0] w_idx;
  logic         w_mis, w_oor;
  logic         w_unused_addr;
  assign w_loading = r_state == IDLE || r_state == ASSEMBLE;
  // Bit W of the length is the full flag: it is only set once all 2**W words exist.
  assign o_load_ready = w_loading & ~r_prog_len[W];
  assign w_hs = i_load_valid & o_load_ready;
  // Flush beats done, and done beats a byte arriving in the same cycle.
  assign w_byte_en = w_hs & ~i_load_done & ~i_flush;
  assign w_pad = w_loading & i_load_done & ~i_flush & w_pending;
  assign w_write = r_state == WRITE && !i_flush;
  assign w_wrap = r_prog_len == (W + 1)'((1 << W) - 1);
  assign w_loaded = r_state == DONE;
  byte_assembler #(.B(B)) u_asm (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (i_flush),
    .i_byte_en   (w_byte_en),
    .i_byte      (i_load_byte),
    .i_pad       (w_pad),
    .o_word      (w_word),
    .o_word_ready(w_word_ready),
    .o_pending   (w_pending)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, ASSEMBLE: begin
        if (i_load_done) w_next = w_pending ? WRITE : DONE;
        else if (w_word_ready) w_next = WRITE;
        else if (w_hs) w_next = ASSEMBLE;
      end
      WRITE: w_next = (r_done_lat || w_wrap) ? DONE : IDLE;
      default: w_next = r_state;
    endcase
    if (i_flush) w_next = IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_prog_len <= '0;
      r_done_lat <= 1'b0;
    end else begin
      r_state <= w_next;
      r_prog_len <= i_flush ? '0 : r_prog_len + (W + 1)'(w_write);
      r_done_lat <= (i_flush || r_state == WRITE) ? 1'b0 : r_done_lat | w_pad;
    end
  end
  // The write pointer is the low W bits of the length; WRITE is never entered when full.
  always_ff @(posedge i_clk) begin
    if (w_write) r_mem[r_prog_len[W-1:0]] <= w_word;
  end
  assign w_idx = i_addr[W+1:2];
  assign w_mis = |i_addr[1:0];
  assign w_oor = {1'b0, w_idx} >= r_prog_len;
  assign w_unused_addr = ^i_addr[PC-1:W+2];
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_instr <= NOP;
      r_instr_valid <= 1'b0;
      r_mis <= 1'b0;
      r_oor <= 1'b0;
    end else if (i_fetch_en) begin
      r_instr_valid <= w_loaded;
      r_mis <= w_loaded & w_mis;
      r_oor <= w_loaded & w_oor;
      r_instr <= (w_loaded && !w_mis && !w_oor) ? r_mem[w_idx] : NOP;
    end else begin
      r_instr_valid <= 1'b0;
    end
  end
  assign o_instr = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_misaligned = r_mis;
  assign o_out_of_range = r_oor;
  assign o_mem_full = r_prog_len[W];
  assign o_prog_len = r_prog_len;
  assign o_loaded = w_loaded;
`ifdef INSTR_MEM_DEBUG_PORT_EN
  logic [B-1:0] r_dbg_data;
  always_ff @(posedge i_clk) r_dbg_data <= r_mem[i_dbg_addr];
  assign o_dbg_data = r_dbg_data;
`endif
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: self-checking bench for instr_mem_loader (W = 2, depth 4)
module tb_instr_mem_loader;
  localparam int W = 2;
  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
    logic        mis;
    logic        oor;
  } fexp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = '0;
  logic        load_ready;
  logic        load_done = 1'b0;
  logic        flush = 1'b0;
  logic        fetch_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] instr;
  logic        instr_valid, misaligned, out_of_range, mem_full, loaded;
  logic [W:0]  prog_len;
  int          n_vec = 0;
  int          n_err = 0;
  fexp_t       sb[$];
  instr_mem_loader #(.B(32), .W(W), .PC(32)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_load_valid  (load_valid),
    .i_load_byte   (load_byte),
    .o_load_ready  (load_ready),
    .i_load_done   (load_done),
    .i_flush       (flush),
    .i_fetch_en    (fetch_en),
    .i_addr        (addr),
    .o_instr       (instr),
    .o_instr_valid (instr_valid),
    .o_misaligned  (misaligned),
    .o_out_of_range(out_of_range),
    .o_mem_full    (mem_full),
    .o_prog_len    (prog_len),
    .o_loaded      (loaded)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready();
    for (int n = 0; n < 4 && !load_ready; n++) tick();
  endtask
  task automatic send_byte(input logic [7:0] b);
    wait_ready();
    load_valid = 1'b1;
    load_byte = b;
    tick();
    load_valid = 1'b0;
  endtask
  task automatic done_strobe();
    wait_ready();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    for (int n = 0; n < 8 && !loaded; n++) tick();
  endtask
  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask
  task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ev, input logic em, input logic eo);
    fexp_t e;
    fetch_en = 1'b1;
    addr = a;
    sb.push_back('{instr: ei, valid: ev, mis: em, oor: eo});
    tick();
    fetch_en = 1'b0;
    e = sb.pop_front();
    check($sformatf("instr@%0h", a), instr, e.instr);
    check($sformatf("valid@%0h", a), instr_valid, e.valid);
    check($sformatf("misaligned@%0h", a), misaligned, e.mis);
    check($sformatf("out_of_range@%0h", a), out_of_range, e.oor);
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("rst_prog_len", prog_len, 0);
    check("rst_ready", load_ready, 1);
    check("rst_loaded", loaded, 0);
    check("rst_full", mem_full, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_flags", {misaligned, out_of_range}, 0);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    fetch(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    done_strobe();
    check("t1_prog_len", prog_len, 1);
    check("t1_loaded", loaded, 1);
    fetch(32'h0, 32'h0010_0013, 1'b1, 1'b0, 1'b0);
    tick();
    check("t1_valid_drop", instr_valid, 0);
    check("t1_instr_hold", instr, 32'h0010_0013);
    fetch(32'h100, 32'h0010_0013, 1'b1, 1'b0, 1'b0);
    fetch(32'h2, 32'h0, 1'b1, 1'b1, 1'b0);
    do_flush();
    check("fl_loaded", loaded, 0);
    check("fl_prog_len", prog_len, 0);
    check("fl_ready", load_ready, 1);
    fetch(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h11); send_byte(8'h22);
    done_strobe();
    check("t2_prog_len", prog_len, 2);
    check("t2_loaded", loaded, 1);
    fetch(32'h4, 32'h0000_2211, 1'b1, 1'b0, 1'b0);
    fetch(32'h0, 32'hDDCC_BBAA, 1'b1, 1'b0, 1'b0);
    fetch(32'h8, 32'h0, 1'b1, 1'b0, 1'b1);
    fetch(32'hA, 32'h0, 1'b1, 1'b1, 1'b1);
    do_flush();
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    tick();
    check("full_after16", mem_full, 1);
    check("full_ready", load_ready, 0);
    for (int i = 16; i < 20; i++) send_byte(8'(i));
    check("full_prog_len", prog_len, 4);
    check("full_ready_hold", load_ready, 0);
    check("full_loaded", loaded, 1);
    fetch(32'h0, 32'h0302_0100, 1'b1, 1'b0, 1'b0);
    fetch(32'hC, 32'h0F0E_0D0C, 1'b1, 1'b0, 1'b0);
    do_flush();
    check("fl2_full", mem_full, 0);
    for (int i = 0; i < 10; i++) send_byte(8'h40 + 8'(i));
    check("mid_prog_len", prog_len, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_prog_len", prog_len, 0);
    check("mid_rst_ready", load_ready, 1);
    check("mid_rst_loaded", loaded, 0);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    done_strobe();
    check("reload_prog_len", prog_len, 1);
    fetch(32'h0, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    fetch(32'h4, 32'h0, 1'b1, 1'b0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
